// File: rtl/fir_filter.sv
// 16-tap antisymmetric (type IV) high-pass FIR, one sample in and one sample out per clock.
// Folded direct form: the coefficient symmetry lets each pair of taps share one multiplier.
module fir_filter #(
    parameter int N    = 16,
    parameter int TAPS = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    output logic [N-1:0] data_out
);

    localparam int HALF  = TAPS / 2;
    localparam int CW    = 16;
    localparam int PW    = N + 1 + CW;
    localparam int ACC_W = 36;

    // Left half of the coefficient set; the right half is its negated mirror image.
    function automatic logic signed [CW-1:0] coef(input int k);
        logic signed [CW-1:0] c;
        case (k)
            0:       c = -16'sd160;
            1:       c = -16'sd240;
            2:       c = -16'sd380;
            3:       c = -16'sd580;
            4:       c = -16'sd880;
            5:       c = -16'sd1350;
            6:       c = -16'sd2250;
            7:       c = -16'sd6500;
            default: c = 16'sd0;
        endcase
        return c;
    endfunction

    logic signed [N-1:0]     taps_q    [TAPS];
    logic signed [N-1:0]     taps_next [TAPS];
    logic signed [N:0]       fold      [HALF];
    logic signed [PW-1:0]    prod      [HALF];
    logic signed [ACC_W-1:0] acc;

    // The output uses the post-shift line, so the freshly captured sample is already in tap 0.
    always_comb begin
        taps_next[0] = data_in;
        for (int k = 1; k < TAPS; k++) begin
            taps_next[k] = taps_q[k-1];
        end
    end

    // h[15-k] = -h[k], so h[k]*x[k] + h[15-k]*x[15-k] = h[k]*(x[k] - x[15-k]).
    always_comb begin
        acc = '0;
        for (int k = 0; k < HALF; k++) begin
            fold[k] = {taps_next[k][N-1], taps_next[k]}
                    - {taps_next[TAPS-1-k][N-1], taps_next[TAPS-1-k]};
            prod[k] = fold[k] * coef(k);
            acc     = acc + {{(ACC_W-PW){prod[k][PW-1]}}, prod[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                taps_q[k] <= '0;
            end
            data_out <= '0;
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                taps_q[k] <= taps_next[k];
            end
            // Arithmetic shift floors toward -inf; the sum magnitude never exceeds N bits.
            data_out <= N'(acc >>> 15);
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: randomized and directed stimulus against a
// plain-arithmetic convolution model of the 16-tap filter.
module tb_fir_filter;

    logic        clk;
    logic        reset;
    logic [15:0] data_in;
    logic [15:0] data_out;

    int checks = 0;
    int errors = 0;

    int     h [16] = '{-160, -240, -380, -580, -880, -1350, -2250, -6500,
                       6500, 2250, 1350, 880, 580, 380, 240, 160};
    int     imp [16] = '{-80, -120, -190, -290, -440, -675, -1125, -3250,
                         3250, 1125, 675, 440, 290, 190, 120, 80};
    longint hist [16];

    fir_filter dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample across one rising edge and return the model's expected output.
    task automatic step(input logic [15:0] d, input logic r, output logic [15:0] exp_out);
        longint sum;
        longint q;
        data_in = d;
        reset   = r;
        @(posedge clk);
        #1;
        if (r) begin
            for (int k = 0; k < 16; k++) hist[k] = 0;
        end else begin
            for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = longint'($signed(d));
        end
        sum = 0;
        for (int k = 0; k < 16; k++) sum += longint'(h[k]) * hist[k];
        q = sum >>> 15;
        exp_out = q[15:0];
    endtask

    task automatic test_reset();
        logic [15:0] e;
        for (int i = 0; i < 2; i++) begin
            step(16'h7FFF, 1'b1, e);
            checks++;
            if (data_out !== 16'h0000) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %0d want 0", i, $signed(data_out));
            end
        end
        step(16'h0000, 1'b0, e);
        checks++;
        if (data_out !== 16'h0000 || data_out !== e) begin
            errors++;
            $display("FAIL reset_first_out: got %0d want 0", $signed(data_out));
        end
    endtask

    task automatic run_impulse(input string tag);
        logic [15:0] e;
        step(16'h4000, 1'b0, e);
        for (int i = 0; i < 17; i++) begin
            logic [15:0] want;
            want = (i < 16) ? 16'(imp[i]) : 16'h0000;
            checks++;
            if (data_out !== want || data_out !== e) begin
                errors++;
                $display("FAIL %s tap %0d: got %0d want %0d model %0d",
                         tag, i, $signed(data_out), $signed(want), $signed(e));
            end
            step(16'h0000, 1'b0, e);
        end
    endtask

    task automatic test_impulse();
        logic [15:0] e;
        step(16'h0000, 1'b1, e);
        run_impulse("impulse");
    endtask

    task automatic test_dc();
        logic [15:0] e;
        step(16'h0000, 1'b1, e);
        for (int i = 0; i < 24; i++) begin
            step(16'h1000, 1'b0, e);
            checks++;
            if (data_out !== e || (i >= 15 && data_out !== 16'h0000)) begin
                errors++;
                $display("FAIL dc sample %0d: got %0d want %0d", i, $signed(data_out), $signed(e));
            end
        end
    endtask

    task automatic test_nyquist();
        logic [15:0] e;
        logic [15:0] d;
        step(16'h0000, 1'b1, e);
        for (int i = 0; i < 24; i++) begin
            d = (i % 2 == 0) ? 16'h4000 : 16'hC000;
            step(d, 1'b0, e);
            checks++;
            if (data_out !== e ||
                (i >= 15 && data_out !== ((d == 16'h4000) ? 16'sd5000 : -16'sd5000))) begin
                errors++;
                $display("FAIL nyquist sample %0d: got %0d model %0d", i, $signed(data_out), $signed(e));
            end
        end
    endtask

    task automatic test_extremes();
        logic [15:0] e;
        logic [15:0] d;
        for (int pol = 0; pol < 2; pol++) begin
            step(16'h0000, 1'b1, e);
            for (int i = 0; i < 16; i++) begin
                d = ((h[15-i] > 0) ^ (pol == 1)) ? 16'sd32767 : -16'sd32767;
                step(d, 1'b0, e);
            end
            checks++;
            if (data_out !== e || data_out !== ((pol == 0) ? 16'sd24679 : -16'sd24680)) begin
                errors++;
                $display("FAIL extremes pol %0d: got %0d model %0d", pol, $signed(data_out), $signed(e));
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] e;
        step(16'h0000, 1'b1, e);
        step(16'h4000, 1'b0, e);
        for (int i = 0; i < 5; i++) step(16'h0000, 1'b0, e);
        step(16'h0000, 1'b1, e);
        checks++;
        if (data_out !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset_out: got %0d want 0", $signed(data_out));
        end
        run_impulse("mid_reset_impulse");
    endtask

    task automatic test_random();
        logic [15:0] e;
        logic [15:0] d;
        logic        r;
        step(16'h0000, 1'b1, e);
        for (int i = 0; i < 400; i++) begin
            d = 16'($urandom_range(0, 65535));
            r = ($urandom_range(0, 99) == 0);
            step(d, r, e);
            checks++;
            if (data_out !== e) begin
                errors++;
                $display("FAIL random cycle %0d: got %0d want %0d", i, $signed(data_out), $signed(e));
            end
        end
    endtask

    initial begin
        data_in = 16'h0000;
        reset   = 1'b1;
        for (int k = 0; k < 16; k++) hist[k] = 0;
        test_reset();
        test_impulse();
        test_dc();
        test_nyquist();
        test_extremes();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
